// File: rtl/kernel_seq_pkg.sv
// Shared types and default sizing for the kernel sequencer slice.
// The state encoding is 3 bits. The sizing defaults match the AXI-Lite register map.
package kernel_seq_pkg;

    localparam int TILE_BYTES_DEF = 1024;
    localparam int ADDR_W_DEF     = 64;
    localparam int CNT_W_DEF      = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_REQ,
        S_LD_WAIT,
        S_CMP,
        S_CMP_WAIT,
        S_DRAIN,
        S_DRAIN_WAIT,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/tile_addr_gen.sv
// Tile walker: holds the current A/B tile addresses and the K-tile index.
// It flags the first tile and the last tile of the run.
module tile_addr_gen
    import kernel_seq_pkg::*;
#(
    parameter int TILE_BYTES = TILE_BYTES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [CNT_W-1:0]  n_tiles,
    input  logic              step,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              first,
    output logic              last
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(TILE_BYTES);

    logic [CNT_W-1:0] k;

    // Address sums wrap modulo 2^ADDR_W. Wrap-around is silent by design.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            addr_a <= '0;
            addr_b <= '0;
            k      <= '0;
        end else if (load) begin
            addr_a <= base_a;
            addr_b <= base_b;
            k      <= '0;
        end else if (step) begin
            addr_a <= addr_a + STRIDE;
            addr_b <= addr_b + STRIDE;
            k      <= k + CNT_W'(1);
        end
    end

    assign first = (k == '0);
    assign last  = (k == n_tiles - CNT_W'(1));

endmodule

// File: rtl/kernel_seq_ctrl.sv
// Kernel sequencer: for each K-tile it issues a load and then a compute. After the last tile
// it drains the accumulators and finishes with the ap_done/ap_ready pulse to the control slave.
//
// Handshake: a load request transfers on a cycle with ld_valid && ld_ready. While ld_valid is
// high and ld_ready is low, ld_valid and both addresses hold steady. The *_start, ap_done and
// *_done signals are single-cycle pulses. A done pulse counts only in its matching wait state.
module kernel_seq_ctrl
    import kernel_seq_pkg::*;
#(
    parameter int TILE_BYTES = TILE_BYTES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_ready,
    output logic              ap_idle,
    input  logic [CNT_W-1:0]  scalar00,
    input  logic [ADDR_W-1:0] A,
    input  logic [ADDR_W-1:0] B,
    output logic              ld_valid,
    input  logic              ld_ready,
    output logic [ADDR_W-1:0] ld_addr_a,
    output logic [ADDR_W-1:0] ld_addr_b,
    input  logic              ld_done,
    output logic              cmp_start,
    output logic              cmp_first,
    output logic              cmp_last,
    input  logic              cmp_done,
    output logic              drain_start,
    input  logic              drain_done,
    output logic [2:0]        state_dbg
);

    seq_state_e       state, state_next;
    logic [CNT_W-1:0] n_tiles;
    logic             load, step, first, last;

    tile_addr_gen #(
        .TILE_BYTES(TILE_BYTES),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W)
    ) u_tile_addr_gen (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .load   (load),
        .base_a (A),
        .base_b (B),
        .n_tiles(n_tiles),
        .step   (step),
        .addr_a (ld_addr_a),
        .addr_b (ld_addr_b),
        .first  (first),
        .last   (last)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state   <= S_IDLE;
            n_tiles <= '0;
        end else begin
            state <= state_next;
            if (load) n_tiles <= scalar00;
        end
    end

    // All outputs decode from the state register. Reset forces them at once.
    always_comb begin
        state_next  = state;
        load        = 1'b0;
        step        = 1'b0;
        ap_done     = 1'b0;
        ap_ready    = 1'b0;
        ap_idle     = 1'b0;
        ld_valid    = 1'b0;
        cmp_start   = 1'b0;
        cmp_first   = 1'b0;
        cmp_last    = 1'b0;
        drain_start = 1'b0;
        case (state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    load       = 1'b1;
                    state_next = (scalar00 == '0) ? S_DONE : S_LD_REQ;
                end
            end
            S_LD_REQ: begin
                ld_valid = 1'b1;
                if (ld_ready) state_next = S_LD_WAIT;
            end
            S_LD_WAIT: begin
                if (ld_done) state_next = S_CMP;
            end
            S_CMP: begin
                cmp_start  = 1'b1;
                cmp_first  = first;
                cmp_last   = last;
                state_next = S_CMP_WAIT;
            end
            S_CMP_WAIT: begin
                if (cmp_done) begin
                    if (last) begin
                        state_next = S_DRAIN;
                    end else begin
                        step       = 1'b1;
                        state_next = S_LD_REQ;
                    end
                end
            end
            S_DRAIN: begin
                drain_start = 1'b1;
                state_next  = S_DRAIN_WAIT;
            end
            S_DRAIN_WAIT: begin
                if (drain_done) state_next = S_DONE;
            end
            S_DONE: begin
                ap_done    = 1'b1;
                ap_ready   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign state_dbg = state;

endmodule
